// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl: issues a common start pulse to N workers and signals proceed when the join policy is met
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   go, mode     launch request (taken only while idle) and join policy (00/11 all, 01 any, 10 none)
//   done         per-worker completion pulses, counted only for pending workers
//   start        one-cycle start pulse to every worker
//   proceed      one-cycle pulse when the join policy is satisfied
//   busy         high from launch until every worker has completed
//   pending      workers started but not yet done
//   first_id     lowest-index worker among the first completions of the run
//   join_cycles  saturating cycles from start to the join event
module fork_join_ctrl #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [1:0]           mode,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         start,
    output logic                 proceed,
    output logic                 busy,
    output logic [N-1:0]         pending,
    output logic [$clog2(N)-1:0] first_id,
    output logic [W-1:0]         join_cycles
);
    localparam int IW = $clog2(N);
    localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, DRAIN = 2'd3;
    localparam logic [1:0] JOIN_ANY = 2'b01, JOIN_NONE = 2'b10;
    logic [1:0]    state, mode_q;
    logic [W-1:0]  cnt, cnt_inc;
    logic [N-1:0]  clr, left;
    logic [IW-1:0] low_id;
    logic          first_seen, join_met;
    always_comb begin
        clr = (state == WAIT || state == DRAIN) ? done & pending : '0;
        left = pending & ~clr;
        cnt_inc = &cnt ? cnt : cnt + 1'b1;
        // join all is met by the completion that empties pending
        join_met = state == WAIT && (mode_q == JOIN_ANY ? |clr : |clr && ~|left);
        low_id = '0;
        for (int i = N - 1; i >= 0; i--)
            if (clr[i]) low_id = IW'(i);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= 2'b00;
            cnt         <= '0;
            first_seen  <= 1'b0;
            start       <= '0;
            proceed     <= 1'b0;
            busy        <= 1'b0;
            pending     <= '0;
            first_id    <= '0;
            join_cycles <= '0;
        end else begin
            start   <= '0;
            proceed <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state      <= LAUNCH;
                    start      <= '1;
                    busy       <= 1'b1;
                    pending    <= '1;
                    cnt        <= '0;
                    mode_q     <= mode;
                    first_seen <= 1'b0;
                    // join_none releases the master together with the start pulse
                    if (mode == JOIN_NONE) begin
                        proceed     <= 1'b1;
                        join_cycles <= '0;
                    end
                end
                LAUNCH: state <= mode_q == JOIN_NONE ? DRAIN : WAIT;
                default: begin
                    cnt     <= cnt_inc;
                    pending <= left;
                    if (|clr && !first_seen) begin
                        first_seen <= 1'b1;
                        first_id   <= low_id;
                    end
                    if (join_met) begin
                        proceed     <= 1'b1;
                        join_cycles <= cnt_inc;
                    end
                    if (~|left) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (join_met) state <= DRAIN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fork_join_ctrl.sv
// tb_fork_join_ctrl: directed self-checking bench for fork_join_ctrl
module tb_fork_join_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       go = 1'b0, go2 = 1'b0;
    logic [1:0] mode = 2'b00, mode2 = 2'b00;
    logic [1:0] done = 2'b00, done2 = 2'b00;
    logic [1:0] start, pending, start2, pending2;
    logic       proceed, busy, proceed2, busy2;
    logic       first_id, first_id2;
    logic [7:0] join_cycles;
    logic [3:0] join_cycles2;
    int errors = 0, checks = 0, pc = 0;
    always #5 clk = ~clk;
    fork_join_ctrl #(.N(2), .W(8)) dut (
        .clk(clk), .rst(rst), .go(go), .mode(mode), .done(done), .start(start), .proceed(proceed),
        .busy(busy), .pending(pending), .first_id(first_id), .join_cycles(join_cycles));
    fork_join_ctrl #(.N(2), .W(4)) dut_sat (
        .clk(clk), .rst(rst), .go(go2), .mode(mode2), .done(done2), .start(start2), .proceed(proceed2),
        .busy(busy2), .pending(pending2), .first_id(first_id2), .join_cycles(join_cycles2));
    task automatic tick;
        @(posedge clk);
        #1;
        if (proceed) pc++;
    endtask
    task automatic launch(input logic [1:0] m);
        go = 1'b1;
        mode = m;
        tick();
        go = 1'b0;
    endtask
    task automatic test_reset;
        repeat (2) tick();
        checks++; if (start !== 2'b00) begin errors++; $display("FAIL reset_start: got %b want 00", start); end
        checks++; if (proceed !== 1'b0) begin errors++; $display("FAIL reset_proceed: got %b want 0", proceed); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL reset_pending: got %b want 00", pending); end
        checks++; if (join_cycles !== 8'd0) begin errors++; $display("FAIL reset_join_cycles: got %0d want 0", join_cycles); end
        rst = 1'b0;
        tick();
    endtask
    task automatic test_join_any;
        pc = 0;
        launch(2'b01);
        checks++; if (start !== 2'b11) begin errors++; $display("FAIL any_start: got %b want 11", start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL any_busy_launch: got %b want 1", busy); end
        repeat (20) tick();
        done = 2'b01;
        tick();
        done = 2'b00;
        checks++; if (proceed !== 1'b1) begin errors++; $display("FAIL any_proceed: got %b want 1", proceed); end
        checks++; if (join_cycles !== 8'd20) begin errors++; $display("FAIL any_join_cycles: got %0d want 20", join_cycles); end
        checks++; if (first_id !== 1'b0) begin errors++; $display("FAIL any_first_id: got %0d want 0", first_id); end
        checks++; if (pending !== 2'b10) begin errors++; $display("FAIL any_pending: got %b want 10", pending); end
        repeat (9) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL any_busy_drain: got %b want 1", busy); end
        done = 2'b10;
        tick();
        done = 2'b00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL any_busy_end: got %b want 0", busy); end
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL any_pending_end: got %b want 00", pending); end
        checks++; if (pc !== 1) begin errors++; $display("FAIL any_proceed_count: got %0d want 1", pc); end
    endtask
    task automatic test_join_all;
        pc = 0;
        launch(2'b00);
        repeat (20) tick();
        done = 2'b01;
        tick();
        done = 2'b00;
        checks++; if (proceed !== 1'b0) begin errors++; $display("FAIL all_early_proceed: got %b want 0", proceed); end
        checks++; if (pending !== 2'b10) begin errors++; $display("FAIL all_pending: got %b want 10", pending); end
        repeat (9) tick();
        done = 2'b10;
        tick();
        done = 2'b00;
        checks++; if (proceed !== 1'b1) begin errors++; $display("FAIL all_proceed: got %b want 1", proceed); end
        checks++; if (join_cycles !== 8'd30) begin errors++; $display("FAIL all_join_cycles: got %0d want 30", join_cycles); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL all_busy: got %b want 0", busy); end
        checks++; if (first_id !== 1'b0) begin errors++; $display("FAIL all_first_id: got %0d want 0", first_id); end
        tick();
        checks++; if (pc !== 1) begin errors++; $display("FAIL all_proceed_count: got %0d want 1", pc); end
    endtask
    task automatic test_join_none;
        pc = 0;
        launch(2'b10);
        checks++; if (start !== 2'b11) begin errors++; $display("FAIL none_start: got %b want 11", start); end
        checks++; if (proceed !== 1'b1) begin errors++; $display("FAIL none_proceed: got %b want 1", proceed); end
        checks++; if (join_cycles !== 8'd0) begin errors++; $display("FAIL none_join_cycles: got %0d want 0", join_cycles); end
        repeat (4) tick();
        done = 2'b10;
        tick();
        done = 2'b00;
        checks++; if (first_id !== 1'b1) begin errors++; $display("FAIL none_first_id: got %0d want 1", first_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL none_busy: got %b want 1", busy); end
        checks++; if (pending !== 2'b01) begin errors++; $display("FAIL none_pending: got %b want 01", pending); end
        done = 2'b01;
        tick();
        done = 2'b00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL none_busy_end: got %b want 0", busy); end
        checks++; if (pc !== 1) begin errors++; $display("FAIL none_proceed_count: got %0d want 1", pc); end
    endtask
    task automatic test_simultaneous;
        pc = 0;
        launch(2'b01);
        tick();
        done = 2'b11;
        tick();
        done = 2'b00;
        checks++; if (first_id !== 1'b0) begin errors++; $display("FAIL simul_first_id: got %0d want 0", first_id); end
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL simul_pending: got %b want 00", pending); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy: got %b want 0", busy); end
        checks++; if (join_cycles !== 8'd1) begin errors++; $display("FAIL simul_join_cycles: got %0d want 1", join_cycles); end
        tick();
        checks++; if (pc !== 1) begin errors++; $display("FAIL simul_proceed_count: got %0d want 1", pc); end
    endtask
    task automatic test_go_ignored;
        launch(2'b01);
        tick();
        done = 2'b10;
        tick();
        done = 2'b00;
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++; if (start !== 2'b00) begin errors++; $display("FAIL drain_go_start: got %b want 00", start); end
        done = 2'b01;
        tick();
        done = 2'b00;
        tick();
        checks++; if (start !== 2'b00) begin errors++; $display("FAIL go_not_queued: got %b want 00", start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL go_not_queued_busy: got %b want 0", busy); end
        done = 2'b11;
        tick();
        done = 2'b00;
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL idle_done_pending: got %b want 00", pending); end
    endtask
    task automatic test_saturation;
        go2 = 1'b1;
        mode2 = 2'b00;
        tick();
        go2 = 1'b0;
        repeat (40) tick();
        done2 = 2'b11;
        tick();
        done2 = 2'b00;
        checks++; if (join_cycles2 !== 4'd15) begin errors++; $display("FAIL sat_join_cycles: got %0d want 15", join_cycles2); end
        checks++; if (proceed2 !== 1'b1) begin errors++; $display("FAIL sat_proceed: got %b want 1", proceed2); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL sat_busy: got %b want 0", busy2); end
    endtask
    task automatic test_reset_mid_wait;
        pc = 0;
        launch(2'b00);
        repeat (5) tick();
        checks++; if (pending !== 2'b11) begin errors++; $display("FAIL abort_pending_before: got %b want 11", pending); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (pending !== 2'b00) begin errors++; $display("FAIL abort_pending: got %b want 00", pending); end
        checks++; if (join_cycles !== 8'd0) begin errors++; $display("FAIL abort_join_cycles: got %0d want 0", join_cycles); end
        checks++; if (first_id !== 1'b0) begin errors++; $display("FAIL abort_first_id: got %0d want 0", first_id); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (pc !== 0) begin errors++; $display("FAIL abort_proceed_count: got %0d want 0", pc); end
        launch(2'b01);
        checks++; if (start !== 2'b11) begin errors++; $display("FAIL relaunch_start: got %b want 11", start); end
        repeat (20) tick();
        done = 2'b01;
        tick();
        done = 2'b00;
        checks++; if (join_cycles !== 8'd20) begin errors++; $display("FAIL relaunch_join_cycles: got %0d want 20", join_cycles); end
        done = 2'b10;
        tick();
        done = 2'b00;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL relaunch_busy: got %b want 0", busy); end
    endtask
    initial begin
        test_reset();
        test_join_any();
        test_join_all();
        test_join_none();
        test_simultaneous();
        test_go_ignored();
        test_saturation();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
